// File: rtl/pmem_arb_pkg.sv
// Shared definitions for the program-memory arbiter.
//   owner_t   : which master owns the read data returning from PMem next cycle
//   WEN_READ  : write-enable value that means "read" (all byte strobes inactive)
//   CNT_W     : width of the starvation and lock counters
package pmem_arb_pkg;

    typedef logic [1:0] owner_t;

    localparam owner_t OWN_NONE = 2'd0;
    localparam owner_t OWN_A    = 2'd1;
    localparam owner_t OWN_B    = 2'd2;

    localparam logic [1:0] WEN_READ = 2'b11;

    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/pmem_arb_sat_cnt.sv
// Saturating up-counter used for the starvation and lock counters.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   inc_i   count up by one, holding at max_i
//   clr_i   clear to zero (wins over inc_i)
//   max_i   saturation value
//   cnt_o   current count
module pmem_arb_sat_cnt
    import pmem_arb_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] max_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q < max_i)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pmem_arbiter.sv
// Two-master arbiter in front of the single-port program memory.
// Master A (CPU frontend/debug) has fixed priority; master B (loader/DMA) is
// protected from starvation and may hold the RAM for a bounded locked burst.
// Ports:
//   ram_clk, ram_rstn           clock, asynchronous active-low reset
//   a_*/b_*  cen,wen,addr,din   master requests (cen/wen low active)
//   b_lock                      B asks to keep ownership across accesses
//   a_wait, b_wait              request present but not granted this cycle
//   a_dout/b_dout, *_rvalid     read data routed to the owning master, 1 cycle after grant
//   ram_cen,wen,addr,din        PMem control, driven by the granted master
//   ram_dout                    PMem read data
module pmem_arbiter
    import pmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_MSB   = 11,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned LOCK_MAX   = 8
) (
    input  logic              ram_clk,
    input  logic              ram_rstn,
    input  logic              a_cen,
    input  logic [1:0]        a_wen,
    input  logic [ADDR_MSB:0] a_addr,
    input  logic [15:0]       a_din,
    input  logic              b_cen,
    input  logic [1:0]        b_wen,
    input  logic [ADDR_MSB:0] b_addr,
    input  logic [15:0]       b_din,
    input  logic              b_lock,
    output logic              a_wait,
    output logic              b_wait,
    output logic [15:0]       a_dout,
    output logic [15:0]       b_dout,
    output logic              a_rvalid,
    output logic              b_rvalid,
    output logic              ram_cen,
    output logic [1:0]        ram_wen,
    output logic [ADDR_MSB:0] ram_addr,
    output logic [15:0]       ram_din,
    input  logic [15:0]       ram_dout
);

    localparam logic [CNT_W-1:0] STARVE_LIM = STARVE_MAX[CNT_W-1:0];
    localparam logic [CNT_W-1:0] LOCK_LIM   = LOCK_MAX[CNT_W-1:0];

    logic             a_req, b_req;
    logic             grant_a, grant_b;
    logic             starve_hit, lock_open;
    logic [CNT_W-1:0] starve_cnt, lock_cnt;
    logic             lock_d, lock_q;
    owner_t           rd_owner_d, rd_owner_q;

    assign a_req = ~a_cen;
    assign b_req = ~b_cen;

    // Grant: B wins when A is idle, inside an unexpired lock, or once starved
    always_comb begin
        starve_hit = (starve_cnt == STARVE_LIM);
        lock_open  = lock_q && (lock_cnt < LOCK_LIM);
        grant_b    = b_req && (!a_req || lock_open || starve_hit);
        grant_a    = a_req && !grant_b;
    end

    assign a_wait = a_req & ~grant_a;
    assign b_wait = b_req & ~grant_b;

    always_comb begin
        ram_cen  = 1'b1;
        ram_wen  = WEN_READ;
        ram_addr = '0;
        ram_din  = '0;
        if (grant_a) begin
            ram_cen  = a_cen;
            ram_wen  = a_wen;
            ram_addr = a_addr;
            ram_din  = a_din;
        end else if (grant_b) begin
            ram_cen  = b_cen;
            ram_wen  = b_wen;
            ram_addr = b_addr;
            ram_din  = b_din;
        end
    end

    // Lock expiry only releases when A is actually waiting; otherwise B keeps going
    always_comb begin
        lock_d = lock_q;
        if (!b_req) begin
            lock_d = 1'b0;
        end else if (grant_b) begin
            lock_d = b_lock;
        end else if (lock_q && (lock_cnt == LOCK_LIM) && a_req) begin
            lock_d = 1'b0;
        end
    end

    always_comb begin
        rd_owner_d = OWN_NONE;
        if (grant_a && (a_wen == WEN_READ)) begin
            rd_owner_d = OWN_A;
        end else if (grant_b && (b_wen == WEN_READ)) begin
            rd_owner_d = OWN_B;
        end
    end

    always_ff @(posedge ram_clk or negedge ram_rstn) begin
        if (!ram_rstn) begin
            lock_q     <= 1'b0;
            rd_owner_q <= OWN_NONE;
        end else begin
            lock_q     <= lock_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    pmem_arb_sat_cnt u_starve_cnt (
        .clk_i  (ram_clk),
        .rst_ni (ram_rstn),
        .inc_i  (b_req & ~grant_b),
        .clr_i  (grant_b | ~b_req),
        .max_i  (STARVE_LIM),
        .cnt_o  (starve_cnt)
    );

    // Counts locked B grants; cleared whenever the lock is dropped
    pmem_arb_sat_cnt u_lock_cnt (
        .clk_i  (ram_clk),
        .rst_ni (ram_rstn),
        .inc_i  (grant_b & b_lock),
        .clr_i  (~lock_d),
        .max_i  (LOCK_LIM),
        .cnt_o  (lock_cnt)
    );

    assign a_rvalid = (rd_owner_q == OWN_A);
    assign b_rvalid = (rd_owner_q == OWN_B);
    assign a_dout   = a_rvalid ? ram_dout : 16'h0000;
    assign b_dout   = b_rvalid ? ram_dout : 16'h0000;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter with a behavioural 1-cycle-latency PMem model.
module tb_pmem_arbiter;

    localparam int unsigned ADDR_MSB = 11;

    logic              ram_clk = 1'b0;
    logic              ram_rstn;
    logic              a_cen, b_cen, b_lock;
    logic [1:0]        a_wen, b_wen;
    logic [ADDR_MSB:0] a_addr, b_addr;
    logic [15:0]       a_din, b_din;
    logic              a_wait, b_wait, a_rvalid, b_rvalid;
    logic [15:0]       a_dout, b_dout;
    logic              ram_cen;
    logic [1:0]        ram_wen;
    logic [ADDR_MSB:0] ram_addr;
    logic [15:0]       ram_din;
    logic [15:0]       ram_dout;

    logic [15:0] mem [0:4095];

    int checks = 0;
    int errors = 0;

    always #5 ram_clk = ~ram_clk;

    pmem_arbiter #(
        .ADDR_MSB   (ADDR_MSB),
        .STARVE_MAX (4),
        .LOCK_MAX   (8)
    ) dut (
        .ram_clk  (ram_clk),
        .ram_rstn (ram_rstn),
        .a_cen    (a_cen),
        .a_wen    (a_wen),
        .a_addr   (a_addr),
        .a_din    (a_din),
        .b_cen    (b_cen),
        .b_wen    (b_wen),
        .b_addr   (b_addr),
        .b_din    (b_din),
        .b_lock   (b_lock),
        .a_wait   (a_wait),
        .b_wait   (b_wait),
        .a_dout   (a_dout),
        .b_dout   (b_dout),
        .a_rvalid (a_rvalid),
        .b_rvalid (b_rvalid),
        .ram_cen  (ram_cen),
        .ram_wen  (ram_wen),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    // PMem model: contents preloaded while reset is held across a clock edge.
    // wen[0] low writes the high byte, wen[1] low writes the low byte.
    always @(posedge ram_clk) begin
        if (!ram_rstn) begin
            ram_dout      <= 16'h0000;
            mem[12'h001]  <= 16'h1111;
            mem[12'h002]  <= 16'h2222;
            mem[12'h003]  <= 16'h3333;
            mem[12'h010]  <= 16'hBEEF;
            mem[12'h020]  <= 16'hABCD;
        end else if (!ram_cen) begin
            if (ram_wen == 2'b11) begin
                ram_dout <= mem[ram_addr];
            end else begin
                if (!ram_wen[0]) mem[ram_addr][15:8] <= ram_din[15:8];
                if (!ram_wen[1]) mem[ram_addr][7:0]  <= ram_din[7:0];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge ram_clk);
        #1;
    endtask

    task automatic drive_a(input logic cen, input logic [1:0] wen,
                           input logic [ADDR_MSB:0] addr, input logic [15:0] din);
        a_cen = cen; a_wen = wen; a_addr = addr; a_din = din;
    endtask

    task automatic drive_b(input logic cen, input logic [1:0] wen,
                           input logic [ADDR_MSB:0] addr, input logic [15:0] din,
                           input logic lock);
        b_cen = cen; b_wen = wen; b_addr = addr; b_din = din; b_lock = lock;
    endtask

    initial begin
        ram_rstn = 1'b0;
        drive_a(1'b1, 2'b11, '0, 16'h0);
        drive_b(1'b1, 2'b11, '0, 16'h0, 1'b0);

        // Reset state
        #2;
        chk("rst_a_rvalid", a_rvalid, 0);
        chk("rst_b_rvalid", b_rvalid, 0);
        chk("rst_a_dout", a_dout, 0);
        chk("rst_ram_cen", ram_cen, 1);
        chk("rst_ram_wen", ram_wen, 2'b11);
        chk("rst_starve", dut.starve_cnt, 0);
        chk("rst_lock", dut.lock_q, 0);
        @(posedge ram_clk);
        @(posedge ram_clk);
        #1 ram_rstn = 1'b1;

        // A reads 0x010
        step;
        drive_a(1'b0, 2'b11, 12'h010, 16'h0);
        #3;
        chk("a_rd_ram_cen", ram_cen, 0);
        chk("a_rd_ram_addr", ram_addr, 12'h010);
        chk("a_rd_wait", a_wait, 0);
        step;
        chk("a_rd_rvalid", a_rvalid, 1);
        chk("a_rd_dout", a_dout, 16'hBEEF);
        chk("a_rd_b_dout", b_dout, 0);
        drive_a(1'b1, 2'b11, '0, 16'h0);

        // Contention: B starved for 4 cycles, granted on the 5th
        step;
        drive_a(1'b0, 2'b11, 12'h001, 16'h0);
        drive_b(1'b0, 2'b11, 12'h002, 16'h0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            #3;
            chk($sformatf("starve_b_wait_c%0d", k), b_wait, 1);
            chk($sformatf("starve_a_wait_c%0d", k), a_wait, 0);
            step;
        end
        #3;
        chk("starve_c5_b_wait", b_wait, 0);
        chk("starve_c5_a_wait", a_wait, 1);
        chk("starve_c5_addr", ram_addr, 12'h002);
        step;
        chk("starve_cleared", dut.starve_cnt, 0);
        chk("starve_b_rvalid", b_rvalid, 1);
        chk("starve_b_dout", b_dout, 16'h2222);
        drive_a(1'b1, 2'b11, '0, 16'h0);
        drive_b(1'b1, 2'b11, '0, 16'h0, 1'b0);

        // B byte write, A idle
        step;
        drive_b(1'b0, 2'b10, 12'h020, 16'h1234, 1'b0);
        #3;
        chk("bwr_b_wait", b_wait, 0);
        chk("bwr_ram_wen", ram_wen, 2'b10);
        chk("bwr_ram_din", ram_din, 16'h1234);
        step;
        drive_b(1'b1, 2'b11, '0, 16'h0, 1'b0);
        chk("bwr_no_a_rvalid", a_rvalid, 0);
        chk("bwr_no_b_rvalid", b_rvalid, 0);
        drive_a(1'b0, 2'b11, 12'h020, 16'h0);
        step;
        chk("bwr_readback", a_dout, 16'h12CD);
        drive_a(1'b1, 2'b11, '0, 16'h0);

        // Locked B burst: 8 grants, then A gets one slot
        step;
        drive_b(1'b0, 2'b11, 12'h005, 16'h0, 1'b1);
        #3;
        chk("lock_c1_b_wait", b_wait, 0);
        step;
        drive_a(1'b0, 2'b11, 12'h001, 16'h0);
        for (int k = 2; k <= 8; k++) begin
            #3;
            chk($sformatf("lock_c%0d_b_wait", k), b_wait, 0);
            chk($sformatf("lock_c%0d_a_wait", k), a_wait, 1);
            step;
        end
        #3;
        chk("lock_c9_a_wait", a_wait, 0);
        chk("lock_c9_b_wait", b_wait, 1);
        step;
        chk("lock_released", dut.lock_q, 0);
        chk("lock_a_rvalid", a_rvalid, 1);
        chk("lock_a_dout", a_dout, 16'h1111);
        #2;
        chk("lock_c10_a_wait", a_wait, 0);
        step;
        drive_a(1'b1, 2'b11, '0, 16'h0);
        drive_b(1'b1, 2'b11, '0, 16'h0, 1'b0);

        // Interleaved reads A(1), B(2), A(3)
        step;
        drive_a(1'b0, 2'b11, 12'h001, 16'h0);
        step;
        chk("il_a1_rvalid", a_rvalid, 1);
        chk("il_a1_dout", a_dout, 16'h1111);
        chk("il_a1_b_dout", b_dout, 0);
        drive_a(1'b1, 2'b11, '0, 16'h0);
        drive_b(1'b0, 2'b11, 12'h002, 16'h0, 1'b0);
        step;
        chk("il_b2_rvalid", b_rvalid, 1);
        chk("il_b2_dout", b_dout, 16'h2222);
        chk("il_b2_a_rvalid", a_rvalid, 0);
        drive_b(1'b1, 2'b11, '0, 16'h0, 1'b0);
        drive_a(1'b0, 2'b11, 12'h003, 16'h0);
        step;
        chk("il_a3_rvalid", a_rvalid, 1);
        chk("il_a3_dout", a_dout, 16'h3333);
        chk("il_a3_b_rvalid", b_rvalid, 0);
        drive_a(1'b1, 2'b11, '0, 16'h0);

        // Reset during a locked B read
        step;
        drive_b(1'b0, 2'b11, 12'h010, 16'h0, 1'b1);
        step;
        chk("rstm_b_rvalid_pre", b_rvalid, 1);
        chk("rstm_lock_pre", dut.lock_q, 1);
        #1 ram_rstn = 1'b0;
        #1;
        chk("rstm_b_rvalid", b_rvalid, 0);
        chk("rstm_b_dout", b_dout, 0);
        chk("rstm_lock", dut.lock_q, 0);
        chk("rstm_lock_cnt", dut.lock_cnt, 0);
        drive_b(1'b1, 2'b11, '0, 16'h0, 1'b0);
        #1 ram_rstn = 1'b1;
        step;
        #2;
        chk("rstm_ram_cen", ram_cen, 1);
        chk("rstm_ram_wen", ram_wen, 2'b11);
        chk("rstm_ram_addr", ram_addr, 0);
        chk("rstm_rvalid_idle", b_rvalid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
